// File: rtl/ahb_ctrl_mul_pkg.sv
// ahb_ctrl_mul_pkg: register map, CMD bit positions and multiplier FSM
// encoding shared by the AHB control/multiplier block.
package ahb_ctrl_mul_pkg;

    // Register offsets, decoded on HADDR[7:0]
    localparam logic [7:0] ADDR_OPA      = 8'h00;
    localparam logic [7:0] ADDR_OPB      = 8'h04;
    localparam logic [7:0] ADDR_CMD      = 8'h08;
    localparam logic [7:0] ADDR_RESULT   = 8'h0C;
    localparam logic [7:0] ADDR_CTRL_VAL = 8'h10;
    localparam logic [7:0] ADDR_CTRL_MOD = 8'h14;
    localparam logic [7:0] ADDR_IRQ_EN   = 8'h18;

    // CMD register bit positions
    localparam int CMD_START  = 0;
    localparam int CMD_DONE   = 1;
    localparam int CMD_BUSY   = 2;
    localparam int CMD_SIGNED = 3;

    // Multiplier FSM state type and encodings
    typedef logic [1:0] mul_state_t;
    localparam mul_state_t ST_IDLE = 2'd0;
    localparam mul_state_t ST_RUN  = 2'd1;
    localparam mul_state_t ST_FIN  = 2'd2;

endpackage

// File: rtl/ahb_ctrl_mul_if.sv
// ahb_ctrl_mul_if: AHB-Lite slave signal bundle for ahb_ctrl_mul.
interface ahb_ctrl_mul_if;
    logic        AHB_HSEL;
    logic [1:0]  AHB_HTRANS;
    logic        AHB_HWRITE;
    logic [31:0] AHB_HADDR;
    logic [31:0] AHB_HWDATA;
    logic [31:0] AHB_HRDATA;
    logic        AHB_HREADY;
    logic [1:0]  AHB_HRESP;

    modport master (
        output AHB_HSEL, AHB_HTRANS, AHB_HWRITE, AHB_HADDR, AHB_HWDATA,
        input  AHB_HRDATA, AHB_HREADY, AHB_HRESP
    );

    modport slave (
        input  AHB_HSEL, AHB_HTRANS, AHB_HWRITE, AHB_HADDR, AHB_HWDATA,
        output AHB_HRDATA, AHB_HREADY, AHB_HRESP
    );
endinterface

// File: rtl/ahb_ctrl_mul_seq_mul.sv
// seq_mul: iterative shift-add multiplier, one partial product per cycle.
// Signed operands are reduced to magnitudes at start; the product is
// negated in FIN when the operand signs differ. The result register holds
// its value until the next FIN.
module seq_mul
    import ahb_ctrl_mul_pkg::*;
#(
    parameter int W = 8
) (
    input  logic           AHB_HCLK,
    input  logic           AHB_HRESETn,
    input  logic           start_i,
    input  logic           signed_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CW = $clog2(W);

    mul_state_t     state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d, mcand_q, mcand_d, prod_q, prod_d;
    logic [W-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           neg_q, neg_d;
    logic [W-1:0]   mag_a, mag_b;

    // Operand magnitudes; -2^(W-1) maps onto 2^(W-1), which still fits in W bits
    always_comb begin
        mag_a = (signed_i && a_i[W-1]) ? -a_i : a_i;
        mag_b = (signed_i && b_i[W-1]) ? -b_i : b_i;
    end

    // Next-state and datapath: IDLE -> RUN (W iterations) -> FIN -> IDLE
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    acc_d    = '0;
                    mcand_d  = (2*W)'(mag_a);
                    mplier_d = mag_b;
                    neg_d    = signed_i & (a_i[W-1] ^ b_i[W-1]);
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                prod_d  = neg_q ? -acc_q : acc_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers, cleared asynchronously even mid-operation
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
        end
    end

    assign busy_o    = (state_q != ST_IDLE);
    assign done_o    = (state_q == ST_FIN);
    assign product_o = prod_q;

endmodule

// File: rtl/ahb_ctrl_mul.sv
// ahb_ctrl_mul: AHB-Lite register block with a sequential multiplier and
// NCTRL game-control outputs (level or fixed-length pulse per channel).
// Optional feature macro: AHB_CTRL_MUL_IRQ_EN enables the IRQ_EN register
// and the registered multiply-done interrupt; otherwise irq_o is tied 0.
module ahb_ctrl_mul
    import ahb_ctrl_mul_pkg::*;
#(
    parameter int W         = 8,
    parameter int NCTRL     = 6,
    parameter int PULSE_LEN = 16
) (
    input  logic             AHB_HCLK,
    input  logic             AHB_HRESETn,
    ahb_ctrl_mul_if.slave    bus,
    output logic [NCTRL-1:0] ctrl_o,
    output logic             irq_o
);
    localparam int PCW = $clog2(PULSE_LEN + 1);

    logic             aph_valid_q, aph_write_q;
    logic [7:0]       aph_addr_q;
    logic [31:0]      wdata, rdata;
    logic             wr_en, rd_en, wr_opa, wr_opb, wr_cmd, wr_val, wr_mode, start;
    logic [W-1:0]     opa_q, opb_q;
    logic             signed_q, done_q, done_d, irq_en_rd;
    logic [NCTRL-1:0] ctrl_mode_q, ctrl_val;
    logic             val_q [NCTRL];
    logic [PCW-1:0]   cnt_q [NCTRL];
    logic             mul_busy, mul_done;
    logic [2*W-1:0]   result;
    logic             unused_bits;

    assign wdata       = bus.AHB_HWDATA;
    assign unused_bits = ^{bus.AHB_HADDR[31:8], bus.AHB_HTRANS[0], wdata};

    // Capture the address phase; HREADY is always 1 so every phase is one cycle
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            aph_valid_q <= 1'b0;
            aph_write_q <= 1'b0;
            aph_addr_q  <= '0;
        end else begin
            aph_valid_q <= bus.AHB_HSEL & bus.AHB_HTRANS[1];
            aph_write_q <= bus.AHB_HWRITE;
            aph_addr_q  <= bus.AHB_HADDR[7:0];
        end
    end

    assign wr_en   = aph_valid_q & aph_write_q;
    assign rd_en   = aph_valid_q & ~aph_write_q;
    assign wr_opa  = wr_en && (aph_addr_q == ADDR_OPA);
    assign wr_opb  = wr_en && (aph_addr_q == ADDR_OPB);
    assign wr_cmd  = wr_en && (aph_addr_q == ADDR_CMD);
    assign wr_val  = wr_en && (aph_addr_q == ADDR_CTRL_VAL);
    assign wr_mode = wr_en && (aph_addr_q == ADDR_CTRL_MOD);
    assign start   = wr_cmd & wdata[CMD_START];

    // SIGNED written alongside START applies to that run; the multiplier
    // latches operands itself, so later writes cannot disturb a run
    seq_mul #(.W(W)) u_mul (
        .AHB_HCLK    (AHB_HCLK),
        .AHB_HRESETn (AHB_HRESETn),
        .start_i     (start),
        .signed_i    (wdata[CMD_SIGNED]),
        .a_i         (opa_q),
        .b_i         (opb_q),
        .busy_o      (mul_busy),
        .done_o      (mul_done),
        .product_o   (result)
    );

    // DONE: completion wins over a same-cycle W1C; START clears it
    always_comb begin
        done_d = done_q;
        if (mul_done) begin
            done_d = 1'b1;
        end else if (start) begin
            done_d = 1'b0;
        end else if (wr_cmd && wdata[CMD_DONE]) begin
            done_d = 1'b0;
        end
    end

    // Software-visible configuration and status registers
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            opa_q       <= '0;
            opb_q       <= '0;
            signed_q    <= 1'b0;
            done_q      <= 1'b0;
            ctrl_mode_q <= '0;
        end else begin
            if (wr_opa)  opa_q       <= wdata[W-1:0];
            if (wr_opb)  opb_q       <= wdata[W-1:0];
            if (wr_cmd)  signed_q    <= wdata[CMD_SIGNED];
            if (wr_mode) ctrl_mode_q <= wdata[NCTRL-1:0];
            done_q <= done_d;
        end
    end

`ifdef AHB_CTRL_MUL_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d = (wr_en && (aph_addr_q == ADDR_IRQ_EN)) ? wdata[0] : irq_en_q;

    // Interrupt built from next-state values so it rises with DONE
    always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
        if (!AHB_HRESETn) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d & irq_en_d;
        end
    end

    assign irq_o     = irq_q;
    assign irq_en_rd = irq_en_q;
`else
    assign irq_o     = 1'b0;
    assign irq_en_rd = 1'b0;
`endif

    // Per-channel control value and pulse counter
    for (genvar gi = 0; gi < NCTRL; gi++) begin : g_ch
        // Mode change cancels a pulse; in pulse mode the count runs while high
        always_ff @(posedge AHB_HCLK or negedge AHB_HRESETn) begin
            if (!AHB_HRESETn) begin
                val_q[gi] <= 1'b0;
                cnt_q[gi] <= '0;
            end else if (wr_mode && (wdata[gi] != ctrl_mode_q[gi])) begin
                if (ctrl_mode_q[gi]) begin
                    val_q[gi] <= 1'b0;
                end else begin
                    // a line held high in level mode becomes one full pulse
                    cnt_q[gi] <= PCW'(PULSE_LEN - 1);
                end
            end else if (wr_val) begin
                val_q[gi] <= wdata[gi];
                cnt_q[gi] <= PCW'(PULSE_LEN - 1);
            end else if (ctrl_mode_q[gi] && val_q[gi]) begin
                if (cnt_q[gi] == '0) begin
                    val_q[gi] <= 1'b0;
                end else begin
                    cnt_q[gi] <= cnt_q[gi] - PCW'(1);
                end
            end
        end
        assign ctrl_val[gi] = val_q[gi];
    end

    // Data-phase read mux; anything that is not a mapped read returns all ones
    always_comb begin
        rdata = 32'hFFFF_FFFF;
        if (rd_en) begin
            case (aph_addr_q)
                ADDR_OPA:      rdata = 32'(opa_q);
                ADDR_OPB:      rdata = 32'(opb_q);
                ADDR_CMD: begin
                    rdata             = '0;
                    rdata[CMD_DONE]   = done_q;
                    rdata[CMD_BUSY]   = mul_busy;
                    rdata[CMD_SIGNED] = signed_q;
                end
                ADDR_RESULT:   rdata = 32'(result);
                ADDR_CTRL_VAL: rdata = 32'(ctrl_val);
                ADDR_CTRL_MOD: rdata = 32'(ctrl_mode_q);
                ADDR_IRQ_EN:   rdata = {31'h0, irq_en_rd};
                default:       rdata = 32'hFFFF_FFFF;
            endcase
        end
    end

    assign bus.AHB_HRDATA = rdata;
    assign bus.AHB_HREADY = 1'b1;
    assign bus.AHB_HRESP  = 2'b00;
    assign ctrl_o         = ctrl_val;

endmodule
